// File: rtl/fc_neuron_mac.sv
// Fully-connected neuron: streams one input vector LANES words per beat against a
// writable weight/bias file, then adds bias, saturates, optionally applies ReLU.
module fc_neuron_mac #(
    parameter int unsigned WORD_SIZE             = 16,
    parameter int unsigned N_SIZE                = 8,
    parameter int unsigned PREVIOUS_LAYER_HEIGHT = 4,
    parameter int unsigned LANES                 = 2,
    parameter bit          RELU_EN               = 1'b0,
    parameter int unsigned LAYER_NUMBER          = 1,
    parameter int unsigned NEURON_NUMBER         = 0
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic [LANES*WORD_SIZE-1:0]                 data_i,
    input  logic                                       valid_i,
    output logic                                       ready_o,
    output logic [WORD_SIZE-1:0]                       data_o,
    output logic                                       valid_o,
    input  logic                                       ready_i,
    input  logic                                       wen_i,
    input  logic [$clog2(PREVIOUS_LAYER_HEIGHT+1)-1:0] waddr_i,
    input  logic [WORD_SIZE-1:0]                       wdata_i
);
    localparam int unsigned W     = WORD_SIZE;
    localparam int unsigned H     = PREVIOUS_LAYER_HEIGHT;
    localparam int unsigned P     = LANES;
    localparam int unsigned BEATS = (H + P - 1) / P;
    localparam int unsigned AW    = $clog2(H + 1);
    localparam int unsigned PW    = 2 * W;
    localparam int unsigned ACC_W = 2 * W + AW;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    if (H < 1 || P < 1 || P > H) begin : g_bad_cfg
        $error("fc_neuron_mac L%0d N%0d: invalid height/lane configuration",
               LAYER_NUMBER, NEURON_NUMBER);
    end

    typedef enum logic [1:0] {ST_ACC, ST_FIN, ST_OUT} state_t;

    state_t                    state_q, state_d;
    logic                      ready_d, valid_d;
    logic [BW-1:0]             beat_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   beat_sum;
    logic signed [ACC_W-1:0]   fin_sum;
    logic signed [PW-1:0]      lane_prod [P];
    logic signed [W-1:0]       wmem [H+1];
    logic [W-1:0]              result;
    logic                      beat_fire;
    logic                      last_beat;

    assign beat_fire = valid_i && ready_o;
    assign last_beat = (beat_q == BW'(BEATS - 1));

    // Weight/bias file: entries 0..H-1 are weights, entry H is the bias; never reset.
    always_ff @(posedge clk_i) begin
        if (wen_i && (waddr_i <= AW'(H))) begin
            wmem[waddr_i] <= wdata_i;
        end
    end

    // Sum of this beat's lane products; lanes past the end of the vector add nothing.
    always_comb begin
        beat_sum = '0;
        for (int l = 0; l < int'(P); l++) begin
            lane_prod[l] = '0;
            if ((int'(beat_q) * int'(P) + l) < int'(H)) begin
                lane_prod[l] = PW'($signed(data_i[l*W +: W]))
                             * PW'(wmem[AW'(int'(beat_q) * int'(P) + l)]);
            end
            beat_sum = beat_sum + ACC_W'(lane_prod[l]);
        end
    end

    // Rescale, add bias, saturate to the word range, optional ReLU.
    always_comb begin
        fin_sum = (acc_q >>> N_SIZE) + ACC_W'(wmem[AW'(H)]);
        if (fin_sum > SAT_MAX) begin
            result = {1'b0, {(W-1){1'b1}}};
        end else if (fin_sum < SAT_MIN) begin
            result = {1'b1, {(W-1){1'b0}}};
        end else begin
            result = fin_sum[W-1:0];
        end
        if (RELU_EN && result[W-1]) begin
            result = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        valid_d = 1'b0;
        unique case (state_q)
            ST_ACC:  if (beat_fire && last_beat) state_d = ST_FIN;
            ST_FIN:  state_d = ST_OUT;
            ST_OUT:  if (ready_i) state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
        ready_d = (state_d == ST_ACC);
        valid_d = (state_d == ST_OUT);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_ACC;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_o <= ready_d;
            valid_o <= valid_d;
        end
    end

    // Accumulator, beat counter and result register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q  <= '0;
            beat_q <= '0;
            data_o <= '0;
        end else begin
            if (state_q == ST_ACC && beat_fire) begin
                acc_q <= acc_q + beat_sum;
                if (!last_beat) begin
                    beat_q <= beat_q + BW'(1);
                end
            end
            if (state_q == ST_FIN) begin
                data_o <= result;
            end
            if (state_q == ST_OUT && ready_i) begin
                acc_q  <= '0;
                beat_q <= '0;
            end
        end
    end
endmodule
